prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 45 ++++
 rtl/prog_loader_word_assembler.sv | 38 +++
 rtl/prog_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, word framing
// constants and stream-position helpers.
// Optional feature: define LOADER_CHECKSUM_EN to add the trailing XOR checksum
// word and the CHK state.
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Position of the header in the word stream, and distance from the last
    // program word to the checksum word.
    localparam int HDR_WORD_POS   = 0;
    localparam int CHK_WORD_OFS   = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHK  = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    // Stream index of the last program word for a header value n.
    function automatic logic [31:0] last_prog_pos(input logic [31:0] n);
        return n + 32'(HDR_WORD_POS);
    endfunction

    // Stream index of the checksum word for a header value n.
    function automatic logic [31:0] checksum_pos(input logic [31:0] n);
        return n + 32'(HDR_WORD_POS) + 32'(CHK_WORD_OFS);
    endfunction

    // States in which the byte stream is being consumed.
    function automatic logic accepts_bytes(input loader_state_t s);
`ifdef LOADER_CHECKSUM_EN
        return (s == HDR) || (s == LOAD) || (s == CHK);
`else
        return (s == HDR) || (s == LOAD);
`endif
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Byte-to-word assembler: collects BYTES_PER_WORD bytes little-endian first
// and pulses word_valid on the cycle after the last byte of a word arrives.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0] byte_cnt;

    // Shift each byte in at the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && (byte_cnt == LAST_BYTE);
            if (byte_en) begin
                word     <= {byte_data, word[31:8]};
                byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: reads a header word N followed by N program words from a
// byte stream, writes them to instruction memory from address 0, and holds the
// core in reset until the load finishes.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing checksum word equal to
// the XOR of the header and all program words, checked in the CHK state.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    loader_state_t     state;
    loader_state_t     state_nx;
    logic              load_clear;
    logic              byte_en;
    logic              word_valid;
    logic [31:0]       word;
    logic [ADDR_W:0]   hdr_n;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W+1:0] word_idx;
    logic              last_prog;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       csum;
    logic              csum_ok;
`endif

    assign load_clear = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign byte_en    = byte_valid && byte_ready;
    assign last_prog  = (32'(word_idx) == last_prog_pos(32'(hdr_n)));
`ifdef LOADER_CHECKSUM_EN
    assign csum_ok    = (32'(word_idx) == checksum_pos(32'(hdr_n))) && (word == csum);
`endif

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_clear),
        .byte_en    (byte_en),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decisions, driven by completed words from the assembler.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx = HDR;
                end
            end
            HDR: begin
                if (word_valid) begin
                    if (word > DEPTH_W) begin
                        state_nx = ERR;
                    end else if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nx = CHK;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_valid && last_prog) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nx = CHK;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (word_valid) begin
                    state_nx = csum_ok ? DONE : ERR;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; write data and address come
    // straight from registers so they are stable for the whole write pulse.
    always_comb begin
        byte_ready = accepts_bytes(state);
        imem_we    = (state == LOAD) && word_valid;
        cpu_hold   = (state != DONE);
        done       = (state == DONE);
        err        = (state == ERR);
        imem_addr  = addr_cnt;
        imem_wdata = word;
    end

    // Header capture, stream word index, write address and checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_n    <= '0;
            addr_cnt <= '0;
            word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (load_clear) begin
            hdr_n    <= '0;
            addr_cnt <= '0;
            word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (word_valid) begin
                word_idx <= word_idx + 1'b1;
            end
            if ((state == HDR) && word_valid) begin
                hdr_n <= word[ADDR_W:0];
            end
            if (imem_we && !last_prog) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (word_valid && ((state == HDR) || (state == LOAD))) begin
                csum <= csum ^ word;
            end
`endif
        end
    end

endmodule
